// File: rtl/audio_mixer.sv
// audio_mixer: mixes CHANNELS unsigned PCM sources into saturated left/right
// levels, one channel per enabled cycle, and drives a first-order
// delta-sigma modulator per side to produce 1-bit audio streams.
module audio_mixer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ce,
    input  logic [CHANNELS*WIDTH-1:0] sample,
    input  logic [CHANNELS*4-1:0]     volume,
    input  logic [CHANNELS-1:0]       pan_l,
    input  logic [CHANNELS-1:0]       pan_r,
    output logic [WIDTH-1:0]          level_l,
    output logic [WIDTH-1:0]          level_r,
    output logic                      sample_stb,
    output logic [1:0]                audio
);
    localparam int IW = $clog2(CHANNELS);
    // Sized so CHANNELS full-scale products at volume 15 never wrap.
    localparam int AW = WIDTH + 4 + IW;
    localparam int MW = AW - 4;

    typedef enum logic {ST_ACC = 1'b0, ST_LATCH = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [WIDTH-1:0]  level_l_q, level_l_d, level_r_q, level_r_d;
    logic [WIDTH:0]    sd_l_q, sd_l_d, sd_r_q, sd_r_d;

    logic [WIDTH-1:0]  cur_smp;
    logic [3:0]        cur_vol;
    logic [WIDTH+3:0]  prod;
    logic [MW-1:0]     m_l, m_r;
    logic [WIDTH-1:0]  sat_l, sat_r;

    // Channel currently selected by the frame index and its weighted sample.
    always_comb begin
        cur_smp = sample[idx_q*WIDTH +: WIDTH];
        cur_vol = volume[idx_q*4 +: 4];
        prod    = (WIDTH+4)'(cur_smp) * (WIDTH+4)'(cur_vol);
    end

    // Drop the 4 gain fraction bits and clip to the output range.
    always_comb begin
        m_l   = acc_l_q[AW-1:4];
        m_r   = acc_r_q[AW-1:4];
        sat_l = (|m_l[MW-1:WIDTH]) ? {WIDTH{1'b1}} : m_l[WIDTH-1:0];
        sat_r = (|m_r[MW-1:WIDTH]) ? {WIDTH{1'b1}} : m_r[WIDTH-1:0];
    end

    // All state registers; reset aborts any frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_ACC;
            idx_q     <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            level_l_q <= '0;
            level_r_q <= '0;
            sd_l_q    <= '0;
            sd_r_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            level_l_q <= level_l_d;
            level_r_q <= level_r_d;
            sd_l_q    <= sd_l_d;
            sd_r_q    <= sd_r_d;
        end
    end

    // Frame sequencing: walk channels 0..CHANNELS-1, then one latch cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (ce) begin
            case (state_q)
                ST_ACC: begin
                    if (idx_q == IW'(CHANNELS-1)) state_d = ST_LATCH;
                    else                          idx_d   = idx_q + 1'b1;
                end
                ST_LATCH: begin
                    state_d = ST_ACC;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_ACC;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Accumulate panned products, latch levels and pulse the strobe.
    always_comb begin
        acc_l_d    = acc_l_q;
        acc_r_d    = acc_r_q;
        level_l_d  = level_l_q;
        level_r_d  = level_r_q;
        sample_stb = 1'b0;
        if (ce) begin
            if (state_q == ST_ACC) begin
                if (pan_l[idx_q]) acc_l_d = acc_l_q + AW'(prod);
                if (pan_r[idx_q]) acc_r_d = acc_r_q + AW'(prod);
            end else begin
                level_l_d  = sat_l;
                level_r_d  = sat_r;
                acc_l_d    = '0;
                acc_r_d    = '0;
                sample_stb = 1'b1;
            end
        end
    end

    // Delta-sigma: the carry out of the low WIDTH bits is the output bit.
    always_comb begin
        sd_l_d = {1'b0, sd_l_q[WIDTH-1:0]} + {1'b0, level_l_q};
        sd_r_d = {1'b0, sd_r_q[WIDTH-1:0]} + {1'b0, level_r_q};
    end

    assign level_l = level_l_q;
    assign level_r = level_r_q;
    assign audio   = {sd_r_q[WIDTH], sd_l_q[WIDTH]};
endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: randomized and directed stimulus with a reference model
// feeding an expected-level queue; a negedge monitor checks the strobe
// every cycle and pops/compares levels when they update.
module tb_audio_mixer;
    localparam int C = 4;
    localparam int W = 8;

    logic           clock, reset, ce;
    logic [C*W-1:0] sample;
    logic [C*4-1:0] volume;
    logic [C-1:0]   pan_l, pan_r;
    logic [W-1:0]   level_l, level_r;
    logic           sample_stb;
    logic [1:0]     audio;

    audio_mixer #(.CHANNELS(C), .WIDTH(W)) dut (
        .clock(clock), .reset(reset), .ce(ce), .sample(sample), .volume(volume),
        .pan_l(pan_l), .pan_r(pan_r), .level_l(level_l), .level_r(level_r),
        .sample_stb(sample_stb), .audio(audio)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { int l; int r; } exp_t;
    exp_t q[$];

    int vectors = 0, miscompares = 0;
    logic started = 1'b0;
    logic exp_stb = 1'b0;
    logic spc_en  = 1'b0;

    // reference model state: slot within frame and running panned sums
    int pos = 0, ml = 0, mr = 0;
    logic [C*W-1:0] cur_smp = '0;
    logic [C*4-1:0] cur_vol = '0;
    logic [C-1:0]   cur_pl = '0, cur_pr = '0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clip(input int acc);
        int m = acc / 16;
        return (m > (1 << W) - 1) ? (1 << W) - 1 : m;
    endfunction

    // one clock: apply current inputs and advance the model
    task automatic cyc(input logic c);
        int s, v;
        exp_t e;
        @(posedge clock); #1;
        ce = c; sample = cur_smp; volume = cur_vol; pan_l = cur_pl; pan_r = cur_pr;
        exp_stb = 1'b0;
        if (c) begin
            if (pos < C) begin
                s = int'(cur_smp[pos*W +: W]);
                v = int'(cur_vol[pos*4 +: 4]);
                if (cur_pl[pos]) ml += s * v;
                if (cur_pr[pos]) mr += s * v;
                pos++;
            end else begin
                exp_stb = 1'b1;
                e.l = clip(ml); e.r = clip(mr);
                q.push_back(e);
                ml = 0; mr = 0; pos = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; ce = 1'b0;
        pos = 0; ml = 0; mr = 0; q.delete(); exp_stb = 1'b0;
        #1;
        chk("rst_level_l", int'(level_l), 0);
        chk("rst_level_r", int'(level_r), 0);
        chk("rst_stb", int'(sample_stb), 0);
        chk("rst_audio", int'(audio), 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        started = 1'b1;
    endtask

    // run until the latch cycle, then one idle cycle so levels are visible
    task automatic frame();
        int n = 0;
        do begin cyc(1'b1); n++; end while (!exp_stb && n < 64);
        if (!exp_stb) chk("frame_timeout", 0, 1);
        cyc(1'b0); #1;
    endtask

    task automatic align();
        int n = 0;
        while (pos != 0 && n < 16) begin cyc(1'b1); n++; end
    endtask

    // monitor: strobe timing every cycle, levels popped after each strobe
    logic pend = 1'b0;
    int   last_l = 0, last_r = 0, ncyc = 0, last_stb = -1;
    always @(negedge clock) begin
        exp_t e;
        ncyc++;
        if (started) begin
            if (!reset) begin
                pend = 1'b0; last_l = 0; last_r = 0;
            end else begin
                chk("stb_timing", int'(sample_stb), int'(exp_stb));
                if (pend) begin
                    if (q.size() == 0) chk("queue_underflow", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("mon_level_l", int'(level_l), e.l);
                        chk("mon_level_r", int'(level_r), e.r);
                        last_l = e.l; last_r = e.r;
                    end
                end else begin
                    chk("hold_level_l", int'(level_l), last_l);
                    chk("hold_level_r", int'(level_r), last_r);
                end
                pend = sample_stb;
                if (!spc_en) last_stb = -1;
                else if (sample_stb) begin
                    if (last_stb >= 0) chk("stb_spacing", ncyc - last_stb, 15);
                    last_stb = ncyc;
                end
            end
        end
    end

    initial begin
        int ones_l, ones_r, toggles;
        logic [1:0] prev_a;
        reset = 1'b1; ce = 1'b0; sample = '0; volume = '0; pan_l = '0; pan_r = '0;
        do_reset();

        // single full-scale channel at volume 15, left only
        cur_smp = 32'h0000_00FF; cur_vol = 16'h000F; cur_pl = 4'b0001; cur_pr = 4'b0000;
        align(); frame();
        chk("single_l", int'(level_l), 8'hEF);
        chk("single_r", int'(level_r), 0);

        // everything full scale on both sides: clips
        cur_smp = 32'hFFFF_FFFF; cur_vol = 16'hFFFF; cur_pl = 4'b1111; cur_pr = 4'b1111;
        align(); frame();
        chk("sat_l", int'(level_l), 8'hFF);
        chk("sat_r", int'(level_r), 8'hFF);

        // half scale at half volume, right only; then bitstream density
        cur_smp = 32'h0000_8000; cur_vol = 16'h0080; cur_pl = 4'b0000; cur_pr = 4'b0010;
        align(); frame(); frame();
        chk("half_l", int'(level_l), 0);
        chk("half_r", int'(level_r), 8'h40);
        ones_l = 0; ones_r = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1'b1); #1;
            ones_l += int'(audio[0]);
            ones_r += int'(audio[1]);
        end
        chk("density_r", ones_r, 64);
        chk("density_l", ones_l, 0);

        // ce one cycle in three: strobes every 15 clocks, audio keeps running
        cur_smp = 32'h0000_00FF; cur_vol = 16'h000F; cur_pl = 4'b0001; cur_pr = 4'b0000;
        align(); frame(); frame();
        spc_en = 1'b1; toggles = 0; prev_a = audio;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1); cyc(1'b0); cyc(1'b0); #1;
            for (int j = 0; j < 1; j++) if (audio[0] != prev_a[0]) toggles++;
            prev_a = audio;
        end
        spc_en = 1'b0;
        chk("audio_toggle", int'(toggles > 0), 1);
        align(); cyc(1'b0); #1;
        chk("slow_ce_l", int'(level_l), 8'hEF);

        // reset mid-frame at k=2, then restart takes exactly 5 enabled cycles
        cur_smp = 32'h9A5C_3377; cur_vol = 16'hFFFF; cur_pl = 4'b1111; cur_pr = 4'b0110;
        align(); frame();
        chk("pre_rst_l_nz", int'(level_l != 0), 1);
        cyc(1'b1); cyc(1'b1);
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1); #1;
            chk("restart_stb", int'(sample_stb), int'(i == 5));
        end
        cyc(1'b0);

        // ch2 changes during k=1: the frame sees the new value
        cur_smp = 32'h0010_0000; cur_vol = 16'h0100; cur_pl = 4'b0100; cur_pr = 4'b0000;
        align();
        cyc(1'b1); cyc(1'b1);
        cur_smp = 32'h00F0_0000;
        frame();
        chk("midframe_l", int'(level_l), 8'h0F);
        chk("midframe_r", int'(level_r), 0);

        // randomized inputs with random ce and mid-frame changes
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 7))
                0: cur_smp = C*W'($urandom);
                1: cur_vol = C*4'($urandom);
                2: cur_pl  = C'($urandom);
                3: cur_pr  = C'($urandom);
                default: ;
            endcase
            cyc($urandom_range(0, 9) < 7);
        end

        repeat (3) cyc(1'b0);
        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Parametrised successor to the two-source ULA/SpecDrum audio path.
- Mixes CHANNELS unsigned PCM sources, each with a 4-bit volume and left/right pan enables, into saturated left and right levels.
- Each level drives an internal first-order delta-sigma modulator that produces a 1-bit output per side.
- Sits between the sound sources (beeper lookup, SpecDrum, AY channels) and the board audio pins.

Parameters:
- CHANNELS, 4, number of input sources (2..8).
- WIDTH, 8, bits per sample and per mixed output level (6..12).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  frame-advance enable. Low freezes the mixer FSM; the modulators keep running.
- sample  in  CHANNELS*WIDTH  packed unsigned samples. Channel i is at [i*WIDTH +: WIDTH].
- volume  in  CHANNELS*4  packed per-channel gain, 0..15.
- pan_l  in  CHANNELS  bit i=1: channel i contributes to the left side.
- pan_r  in  CHANNELS  bit i=1: channel i contributes to the right side.
- level_l  out  WIDTH  latched left mix level.
- level_r  out  WIDTH  latched right mix level.
- sample_stb  out  1  one-cycle pulse when level_l/level_r update.
- audio  out  2  delta-sigma bitstreams; [0]=left, [1]=right.

Behaviour:
- Reset (reset=0, asynchronous) clears everything to 0: FSM index, accumulators, level_l, level_r, sample_stb, both modulator accumulators, audio.
- Frame FSM has two states, ACC and LATCH. One frame is CHANNELS+1 enabled cycles.
  - ACC, index k = 0..CHANNELS-1, one channel per ce=1 cycle:
    - p = sample[k] * volume[k], unsigned, WIDTH+4 bits.
    - acc_l += p if pan_l[k]; acc_r += p if pan_r[k].
    - k = CHANNELS-1 → LATCH.
  - Accumulator width is WIDTH+4+clog2(CHANNELS); it never wraps.
  - LATCH:
    - m = acc >> 4 per side.
    - level = m if m < 2^WIDTH, else 2^WIDTH-1 (saturate).
    - sample_stb=1 this cycle only. Both accumulators clear. k=0. → ACC.
- Inputs are sampled at the moment each channel is accumulated. A change mid-frame affects only channels not yet accumulated.
- ce=0: FSM, accumulators and levels hold; sample_stb=0.
- Latency: level reflects sample[0] taken CHANNELS cycles before the sample_stb cycle. The level is visible the cycle after sample_stb asserts, i.e. when it is registered.
- volume=15 gives gain 15/16, not unity. A single full-scale channel at volume 15 yields floor((2^WIDTH-1)*15/16).
- Delta-sigma modulator per side:
  - runs every clock regardless of ce;
  - state sd, WIDTH+1 bits;
  - sd <= {1'b0, sd[WIDTH-1:0]} + level; audio bit = sd[WIDTH] (registered);
  - the density of 1s over 2^WIDTH clocks equals level/2^WIDTH;
  - level=0 gives constant 0; level=2^WIDTH-1 gives 0 once per 2^WIDTH clocks.
- Reset asserted mid-frame aborts the frame. After release, the frame restarts at k=0 with cleared accumulators and no sample_stb until a full frame completes.
- A channel with both pan bits 0, or volume 0, contributes nothing.

Test Plan:
- CHANNELS=4, WIDTH=8. ch0=8'hFF, vol0=15, pan_l=0001, pan_r=0000, others 0 → after first sample_stb: level_l=8'hEF, level_r=0.
- All four channels 8'hFF, vol=15, pan both=1111 → level_l=level_r=8'hFF (saturation). Sum before shift 15300; 15300>>4=956 clips.
- ch1=8'h80, vol1=8, pan_r only → level_r=8'h40. Over 256 clocks, audio[1] has exactly 64 ones; audio[0] stays 0.
- ce pulsed one cycle in three → sample_stb spaced 15 clocks apart, levels unchanged between strobes, audio keeps toggling.
- reset driven low at k=2 with nonzero inputs → all outputs 0 immediately. After release, first sample_stb arrives exactly 5 enabled cycles later.
- ch2 changed from 8'h10 to 8'hF0 while k=1, vol2=16'h… set to 1, pan_l bit2 → level_l in that frame uses 8'hF0 (value 8'h0F).
